dma_channel: RTL and testbench
==============================

# dma_channel

Single-channel bus master that copies a block of words or halfwords from a source region to a destination region over the CPU memory bus. It drives the same address/write/size/wdata protocol the ARM7TDMI-S core drives and consumes rdata, pause and abort from the memory system, so it is a second initiator alongside the core. It is intended for the GBA DMA controller and as a bus-traffic initiator in the CPU testbench memory system.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; everything samples on the rising edge.
- rst  in  1  reset; synchronous and active-high, one clock.
- start  in  1  begin a transfer; sampled only in IDLE.
- src_addr  in  32  source start address; sampled on the start edge.
- dst_addr  in  32  destination start address; sampled on the start edge.
- count  in  16  number of units to copy; sampled on the start edge. 0 means no transfer.
- half  in  1  unit size: 1 = halfword, 0 = word; sampled on the start edge.
- src_mode, dst_mode  in  2 each  address step after each unit: 00 increment, 01 decrement, 10 fixed, 11 treated as fixed; sampled on the start edge.
- addr  out  32  bus address.
- wdata  out  32  bus write data, presented 1 cycle after its address/write cycle.
- write  out  1  bus write strobe, qualifies addr.
- size  out  2  `MEM_SIZE_WORD or `MEM_SIZE_HALF.
- rdata  in  32  bus read data, valid the cycle after the read address.
- pause  in  1  bus stall; freezes the block.
- abort  in  1  bus error.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  last transfer ended by abort; sticky until the next accepted start.

## Operation
- Internal registers: src_cur, dst_cur, remaining (16b), half_r, modes, data_r.
- Alignment: the block forces alignment on every address. Word units clear addr[1:0]. Halfword units clear addr[0].
- Step size is 4 for words and 2 for halfwords. Increment and decrement wrap modulo 2^32.
- States:
  - IDLE: write=0. addr, size and wdata hold their last values.
    - start with count≠0: load the registers, clear error, go to RD.
    - start with count=0: clear error and pulse done the next cycle. No bus activity.
  - RD: addr=src_cur, write=0, size per half_r. Next state is WR.
  - WR: addr=dst_cur, write=1.
    - Capture rdata into data_r at the end of the cycle. Halfword units take rdata[31:16] if src_cur[1] else rdata[15:0], and set data_r={h,h}.
    - Step src_cur and dst_cur, decrement remaining.
    - Next state is RD if remaining after the decrement ≠0, else TAIL.
  - TAIL: write=0, addr=dst_cur, wdata=data_r. Next state is IDLE with done=1.
- wdata is driven from data_r, so it is valid in the cycle after WR: the following RD, or TAIL. Steady state is 2 cycles per unit, with the write-data phase overlapping the next read address.
- pause=1: no register changes and all outputs hold. rdata and abort are not sampled. A done pulse already high deasserts on the next edge regardless of pause.
- abort=1 on a non-paused edge while busy:
  - Go to IDLE with done=1 and error=1, and set write=0.
  - A write whose data phase has not started is dropped. start is ignored while busy.
- rst: state=IDLE, addr=0, wdata=0, write=0, size=`MEM_SIZE_WORD, busy=0, done=0, error=0, data_r=0. Reset mid-transfer abandons the transfer with no done.

## Timing
- Start sampled at edge E0. RD is cycle 1 and WR is cycle 2; unit k (0-based) occupies cycles 2k+1 and 2k+2.
- TAIL is cycle 2N+1. done=1 and busy=0 in cycle 2N+2, for exactly one cycle.
- busy=1 in cycles 1..2N+1.
- Each paused cycle extends the timeline by one cycle.
- count=0: done=1 in cycle 1, busy never asserts.

## Test plan
- Word copy: src 0x0300_0000 → dst 0x0200_0000, count 4, inc/inc, src preloaded 0x11111111..0x44444444.
  - Bus shows R/W pairs at 0x0300_0000/0x0200_0000 through 0x0300_000C/0x0200_000C.
  - dst memory matches src; done in cycle 10.
- Halfword copy: src 0x0300_0002, dst 0x0200_0000, count 3, half=1.
  - Writes use size `MEM_SIZE_HALF and wdata is replicated {h,h}.
  - Each destination half equals the corresponding source half, including correct upper/lower lane selection.
- Pause: hold pause=1 for 3 cycles starting in unit 1's WR.
  - addr, write and wdata are frozen throughout the pause.
  - done moves from cycle 10 to 13; data is correct.
- Abort: assert abort on the edge ending unit 1's WR (count 4).
  - done=1 and error=1 in the next cycle, write=0.
  - Only unit 0 is written; the next start with count≠0 clears error.
- Modes: dst_mode=fixed, dst 0x0400_00A0, src_mode=dec, src 0x0300_000C, count 4. Bus must show reads at 0x0300_000C, 0x0300_0008, 0x0300_0004, 0x0300_0000 and four writes all to 0x0400_00A0.
- Edge cases:
  - count=0 gives done in cycle 1 with no bus write.
  - start during busy is ignored.
  - rst in unit 2 returns all outputs to their reset values, with no done.

Source files
------------

// File: rtl/dma_channel.sv
// dma_channel: single-channel block copy bus master.
// Second initiator on the core memory bus (addr/write/size/wdata).
`ifndef MEM_SIZE_WORD
`define MEM_SIZE_WORD 2'b10
`endif
`ifndef MEM_SIZE_HALF
`define MEM_SIZE_HALF 2'b01
`endif

module dma_channel (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] count,
  input  logic        half,
  input  logic [1:0]  src_mode,
  input  logic [1:0]  dst_mode,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic        write,
  output logic [1:0]  size,
  input  logic [31:0] rdata,
  input  logic        pause,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_TAIL
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] data_q, data_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d;
  logic        half_q, half_d;
  logic [1:0]  smode_q, smode_d;
  logic [1:0]  dmode_q, dmode_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [31:0] src_nxt;
  logic [31:0] dst_nxt;
  logic [15:0] rem_dec;
  logic [15:0] hword;

  function automatic logic [31:0] align(
    input logic [31:0] a,
    input logic        h
  );
    if (h) align = {a[31:1], 1'b0};
    else   align = {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] step_addr(
    input logic [31:0] a,
    input logic [1:0]  m,
    input logic        h
  );
    logic [31:0] inc;
    inc = h ? 32'd2 : 32'd4;
    case (m)
      2'b00:   step_addr = a + inc;
      2'b01:   step_addr = a - inc;
      default: step_addr = a;
    endcase
  endfunction

  // Next-state and next-output logic; pause freezes all but done.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    half_d  = half_q;
    smode_d = smode_q;
    dmode_d = dmode_q;
    size_d  = size_q;
    write_d = write_q;
    err_d   = err_q;
    done_d  = 1'b0;
    src_nxt = step_addr(src_q, smode_q, half_q);
    dst_nxt = step_addr(dst_q, dmode_q, half_q);
    rem_dec = rem_q - 16'd1;
    hword   = src_q[1] ? rdata[31:16] : rdata[15:0];
    if (!pause) begin
      if (abort && state_q != S_IDLE) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        err_d   = 1'b1;
        write_d = 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              err_d = 1'b0;
              if (count == 16'd0) begin
                done_d = 1'b1;
              end else begin
                state_d = S_RD;
                src_d   = align(src_addr, half);
                dst_d   = align(dst_addr, half);
                rem_d   = count;
                half_d  = half;
                smode_d = src_mode;
                dmode_d = dst_mode;
                addr_d  = align(src_addr, half);
                write_d = 1'b0;
                size_d  = half ? `MEM_SIZE_HALF
                               : `MEM_SIZE_WORD;
              end
            end
          end
          S_RD: begin
            state_d = S_WR;
            addr_d  = dst_q;
            write_d = 1'b1;
          end
          S_WR: begin
            data_d  = half_q ? {hword, hword} : rdata;
            src_d   = src_nxt;
            dst_d   = dst_nxt;
            rem_d   = rem_dec;
            write_d = 1'b0;
            if (rem_dec != 16'd0) begin
              state_d = S_RD;
              addr_d  = src_nxt;
            end else begin
              state_d = S_TAIL;
              addr_d  = dst_nxt;
            end
          end
          S_TAIL: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            write_d = 1'b0;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      half_q  <= 1'b0;
      smode_q <= 2'b00;
      dmode_q <= 2'b00;
      size_q  <= `MEM_SIZE_WORD;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      half_q  <= half_d;
      smode_q <= smode_d;
      dmode_q <= dmode_d;
      size_q  <= size_d;
      write_q <= write_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign addr  = addr_q;
  assign wdata = data_q;
  assign write = write_q;
  assign size  = size_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign error = err_q;

endmodule

// File: tb/tb_dma_channel.sv
// tb_dma_channel: directed bench for dma_channel.
// Small bus memory model answers reads and commits write data phases.
`ifndef MEM_SIZE_WORD
`define MEM_SIZE_WORD 2'b10
`endif
`ifndef MEM_SIZE_HALF
`define MEM_SIZE_HALF 2'b01
`endif

module tb_dma_channel;
  logic        clk = 1'b0;
  logic        rst, start, half;
  logic        write, pause, abort;
  logic        busy, done, error;
  logic [31:0] src_addr, dst_addr;
  logic [31:0] addr, wdata, rdata;
  logic [15:0] count;
  logic [1:0]  src_mode, dst_mode, size;

  int nchk = 0;
  int nerr = 0;
  int wr_cnt;
  int w0;

  logic [31:0] mem [0:255];
  logic        pend, pend_h;
  logic [31:0] pend_a;
  logic        ld_en;
  logic [31:0] ld_a, ld_d;
  logic [31:0] exp_m [0:3];

  always #5 clk = ~clk;

  dma_channel dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr),
    .count(count), .half(half),
    .src_mode(src_mode), .dst_mode(dst_mode),
    .addr(addr), .wdata(wdata), .write(write),
    .size(size), .rdata(rdata),
    .pause(pause), .abort(abort),
    .busy(busy), .done(done), .error(error)
  );

  function automatic logic [7:0] idx(input logic [31:0] a);
    return {a[25:24], a[7:2]};
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic        h,
    input logic        up
  );
    if (!h) return d;
    if (up) return {d[31:16], old[15:0]};
    return {old[31:16], d[15:0]};
  endfunction

  // Bus slave: read data one cycle after address, write data one
  // cycle after the write strobe; aborted writes are dropped.
  always @(posedge clk) begin
    if (rst) begin
      pend   <= 1'b0;
      rdata  <= '0;
      wr_cnt <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (ld_en) begin
      mem[idx(ld_a)] <= ld_d;
    end else if (!pause) begin
      if (pend)
        mem[idx(pend_a)] <= merge(mem[idx(pend_a)], wdata,
                                  pend_h, pend_a[1]);
      pend   <= write && !abort;
      pend_a <= addr;
      pend_h <= (size == `MEM_SIZE_HALF);
      rdata  <= mem[idx(addr)];
      if (write && !abort) wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_a  = a;
    ld_d  = d;
    ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic go(
    input logic [31:0] s,
    input logic [31:0] d,
    input logic [15:0] c,
    input logic        h,
    input logic [1:0]  sm,
    input logic [1:0]  dm
  );
    src_addr = s;
    dst_addr = d;
    count    = c;
    half     = h;
    src_mode = sm;
    dst_mode = dm;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; half = 1'b0;
    src_addr = '0; dst_addr = '0; count = '0;
    src_mode = '0; dst_mode = '0;
    pause = 1'b0; abort = 1'b0; ld_en = 1'b0;
    ld_a = '0; ld_d = '0;
    repeat (2) tick;

    chk("rst_addr", addr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_write", write, 32'd0);
    chk("rst_size", size, `MEM_SIZE_WORD);
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_error", error, 32'd0);
    rst = 1'b0;
    tick;

    // word copy, inc/inc
    for (int k = 0; k < 4; k++)
      load(32'h0300_0000 + 32'(4 * k), 32'h1111_1111 * 32'(k + 1));
    go(32'h0300_0000, 32'h0200_0000, 16'd4, 1'b0, 2'b00, 2'b00);
    for (int k = 0; k < 4; k++) begin
      chk("w_rd_addr", addr, 32'h0300_0000 + 32'(4 * k));
      chk("w_rd_write", write, 32'd0);
      chk("w_busy", busy, 32'd1);
      if (k > 0) chk("w_wdata", wdata, 32'h1111_1111 * 32'(k));
      tick;
      chk("w_wr_addr", addr, 32'h0200_0000 + 32'(4 * k));
      chk("w_wr_write", write, 32'd1);
      chk("w_wr_size", size, `MEM_SIZE_WORD);
      tick;
    end
    chk("w_tail_busy", busy, 32'd1);
    chk("w_tail_write", write, 32'd0);
    chk("w_tail_wdata", wdata, 32'h4444_4444);
    chk("w_tail_done", done, 32'd0);
    tick;
    chk("w_done", done, 32'd1);
    chk("w_done_busy", busy, 32'd0);
    tick;
    chk("w_done_pulse", done, 32'd0);
    for (int k = 0; k < 4; k++)
      chk("w_mem", mem[idx(32'h0200_0000 + 32'(4 * k))],
          32'h1111_1111 * 32'(k + 1));

    // halfword copy with lane selection
    load(32'h0300_0000, 32'hA1A2_B1B2);
    load(32'h0300_0004, 32'hC1C2_D1D2);
    go(32'h0300_0002, 32'h0200_0000, 16'd3, 1'b1, 2'b00, 2'b00);
    chk("h_rd0", addr, 32'h0300_0002);
    chk("h_size", size, `MEM_SIZE_HALF);
    tick;
    chk("h_wr0", addr, 32'h0200_0000);
    chk("h_wr0_size", size, `MEM_SIZE_HALF);
    chk("h_wr0_write", write, 32'd1);
    tick;
    chk("h_rd1", addr, 32'h0300_0004);
    chk("h_wd0", wdata, 32'hA1A2_A1A2);
    tick;
    chk("h_wr1", addr, 32'h0200_0002);
    tick;
    chk("h_rd2", addr, 32'h0300_0006);
    chk("h_wd1", wdata, 32'hD1D2_D1D2);
    tick;
    chk("h_wr2", addr, 32'h0200_0004);
    tick;
    chk("h_wd2", wdata, 32'hC1C2_C1C2);
    chk("h_tail_write", write, 32'd0);
    tick;
    chk("h_done", done, 32'd1);
    chk("h_mem0", mem[idx(32'h0200_0000)], 32'hD1D2_A1A2);
    chk("h_mem1", mem[idx(32'h0200_0004)], 32'h2222_C1C2);

    // pause for 3 cycles in unit 1 WR
    for (int k = 0; k < 4; k++)
      load(32'h0300_0010 + 32'(4 * k), 32'hCAFE_0000 + 32'(k));
    go(32'h0300_0010, 32'h0200_0010, 16'd4, 1'b0, 2'b00, 2'b00);
    repeat (3) tick;
    chk("p_wr1_addr", addr, 32'h0200_0014);
    chk("p_wr1_write", write, 32'd1);
    chk("p_wr1_wdata", wdata, 32'hCAFE_0000);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("p_hold_addr", addr, 32'h0200_0014);
      chk("p_hold_write", write, 32'd1);
      chk("p_hold_wdata", wdata, 32'hCAFE_0000);
    end
    pause = 1'b0;
    tick;
    chk("p_rd2_addr", addr, 32'h0300_0018);
    chk("p_rd2_write", write, 32'd0);
    chk("p_rd2_wdata", wdata, 32'hCAFE_0001);
    repeat (4) tick;
    chk("p_c12_done", done, 32'd0);
    chk("p_c12_busy", busy, 32'd1);
    tick;
    chk("p_c13_done", done, 32'd1);
    for (int k = 0; k < 4; k++)
      chk("p_mem", mem[idx(32'h0200_0010 + 32'(4 * k))],
          32'hCAFE_0000 + 32'(k));

    // abort at the end of unit 1 WR
    w0 = wr_cnt;
    go(32'h0300_0000, 32'h0200_0040, 16'd4, 1'b0, 2'b00, 2'b00);
    repeat (3) tick;
    chk("a_wr1_addr", addr, 32'h0200_0044);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("a_done", done, 32'd1);
    chk("a_error", error, 32'd1);
    chk("a_write", write, 32'd0);
    chk("a_busy", busy, 32'd0);
    tick;
    chk("a_done_pulse", done, 32'd0);
    chk("a_error_sticky", error, 32'd1);
    chk("a_mem0", mem[idx(32'h0200_0040)], 32'hA1A2_B1B2);
    chk("a_mem1", mem[idx(32'h0200_0044)], 32'h0);
    chk("a_wr_cnt", 32'(wr_cnt - w0), 32'd1);

    // src decrement, dst fixed; start while busy is ignored
    exp_m[0] = 32'h4444_4444;
    exp_m[1] = 32'h3333_3333;
    exp_m[2] = 32'hC1C2_D1D2;
    exp_m[3] = 32'hA1A2_B1B2;
    w0 = wr_cnt;
    go(32'h0300_000C, 32'h0400_00A0, 16'd4, 1'b0, 2'b01, 2'b10);
    chk("m_error_clr", error, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("m_rd_addr", addr, 32'h0300_000C - 32'(4 * k));
      if (k > 0) chk("m_wdata", wdata, exp_m[k-1]);
      if (k == 1) begin
        start    = 1'b1;
        count    = 16'd1;
        src_addr = 32'h0300_0000;
        dst_addr = 32'h0200_0000;
      end
      tick;
      start = 1'b0;
      chk("m_wr_addr", addr, 32'h0400_00A0);
      chk("m_wr_write", write, 32'd1);
      tick;
    end
    chk("m_tail_wdata", wdata, 32'hA1A2_B1B2);
    tick;
    chk("m_done", done, 32'd1);
    chk("m_mem", mem[idx(32'h0400_00A0)], 32'hA1A2_B1B2);
    chk("m_wr_cnt", 32'(wr_cnt - w0), 32'd4);

    // count = 0
    w0 = wr_cnt;
    go(32'h0300_0000, 32'h0200_0080, 16'd0, 1'b0, 2'b00, 2'b00);
    chk("z_done", done, 32'd1);
    chk("z_busy", busy, 32'd0);
    chk("z_write", write, 32'd0);
    tick;
    chk("z_done_pulse", done, 32'd0);
    chk("z_busy2", busy, 32'd0);
    chk("z_wr_cnt", 32'(wr_cnt - w0), 32'd0);

    // reset during unit 2
    go(32'h0300_0010, 32'h0200_0060, 16'd4, 1'b1, 2'b00, 2'b00);
    chk("r_size_half", size, `MEM_SIZE_HALF);
    repeat (4) tick;
    rst = 1'b1;
    tick;
    chk("r_addr", addr, 32'h0);
    chk("r_wdata", wdata, 32'h0);
    chk("r_write", write, 32'd0);
    chk("r_size", size, `MEM_SIZE_WORD);
    chk("r_busy", busy, 32'd0);
    chk("r_done", done, 32'd0);
    chk("r_error", error, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("r_no_done", done, 32'd0);
      chk("r_idle", busy, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
